// File: rtl/fp_pkg.sv
// Shared filter-pipeline definitions: config scheduler states, config address
// fields and the meaning of each word slot within a stage.
package fp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_QUIESCE = 3'd1,
        ST_DRAIN   = 3'd2,
        ST_SWAP    = 3'd3,
        ST_RESUME  = 3'd4
    } fp_state_e;

    // cfg_addr layout: [7:3] stage, [2:0] word within the stage
    localparam int STAGE_W = 5;
    localparam int WORD_W  = 3;

    localparam logic [WORD_W-1:0] WORD_BENES      = 3'd0;
    localparam logic [WORD_W-1:0] WORD_KUFPU_FIRST = 3'd1;
    localparam logic [WORD_W-1:0] WORD_KUFPU_LAST  = 3'd4;
    localparam logic [WORD_W-1:0] WORD_BFPU_FIRST  = 3'd5;
    localparam logic [WORD_W-1:0] WORD_BFPU_LAST   = 3'd6;
    localparam logic [WORD_W-1:0] WORD_RSVD        = 3'd7;

    function automatic logic [STAGE_W-1:0] addr_stage(input logic [7:0] addr);
        return addr[7:3];
    endfunction

    function automatic logic [WORD_W-1:0] addr_word(input logic [7:0] addr);
        return addr[2:0];
    endfunction

endpackage

// File: rtl/fp_cfg_bank.sv
// Shadow/active config table pair: words land in shadow, and the whole shadow
// table is copied to active in one edge when swap is asserted.
module fp_cfg_bank
    import fp_pkg::*;
#(
    parameter int STAGES = 2,
    parameter int WPS    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [STAGE_W-1:0]       wr_stage,
    input  logic [WORD_W-1:0]        wr_word,
    input  logic [31:0]              wr_data,
    input  logic                     swap,
    output logic [STAGES*WPS*32-1:0] act_cfg
);

    localparam int NENT = STAGES * WPS;
    localparam int IW   = (NENT > 1) ? $clog2(NENT) : 1;

    logic [NENT*32-1:0] shadow_q;
    logic [NENT*32-1:0] active_q;
    logic [IW-1:0]      wr_idx;

    assign wr_idx  = IW'(wr_stage) * IW'(WPS) + IW'(wr_word);
    assign act_cfg = active_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_q <= '0;
            active_q <= '0;
        end else begin
            if (wr_en) begin
                shadow_q[{wr_idx, 5'd0} +: 32] <= wr_data;
            end
            // Writes and swap never coincide, so active always takes a settled table
            if (swap) begin
                active_q <= shadow_q;
            end
        end
    end

endmodule

// File: rtl/fp_cfg_sched.sv
// Config scheduler: stages words into a shadow table and commits them to the
// filter pipeline only after blocking upstream input and draining the pipe.
module fp_cfg_sched
    import fp_pkg::*;
#(
    parameter int INPUTS = 4,
    parameter int STAGES = 2,
    parameter int WPS    = 8,
    parameter int DRAIN  = 2 * STAGES
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [7:0]               cfg_addr,
    input  logic [31:0]              cfg_data,
    input  logic                     commit_req,
    output logic                     commit_ack,
    output logic                     src_en,
    output logic [STAGES*WPS*32-1:0] act_cfg,
    output logic                     busy,
    output logic                     err,
    output logic [2:0]               state_dbg
);

    if (INPUTS < 1 || STAGES < 1 || STAGES > 32 || WPS < 1 || WPS > 8 || DRAIN < 1) begin : g_bad_params
        $error("fp_cfg_sched: parameter out of range");
    end

    localparam int CW = (DRAIN > 1) ? $clog2(DRAIN) : 1;

    fp_state_e         state_q, state_nx;
    logic [CW-1:0]     cnt_q, cnt_nx;
    logic              armed_q;
    logic              err_q;
    logic              launch;
    logic              swap;
    logic [STAGE_W-1:0] cfg_stage;
    logic [WORD_W-1:0]  cfg_word;
    logic              accept;
    logic              addr_ok;

    // Handshake: a word transfers on any edge where cfg_valid && cfg_ready;
    // cfg_ready depends only on state, never on cfg_valid.
    assign cfg_stage = addr_stage(cfg_addr);
    assign cfg_word  = addr_word(cfg_addr);
    assign accept    = cfg_valid && cfg_ready;
    assign addr_ok   = (int'(cfg_stage) < STAGES) && (int'(cfg_word) < WPS);

    always_comb begin
        state_nx = state_q;
        cnt_nx   = cnt_q;
        launch   = 1'b0;
        swap     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (commit_req && armed_q) begin
                    state_nx = ST_QUIESCE;
                    launch   = 1'b1;
                end
            end
            ST_QUIESCE: begin
                state_nx = ST_DRAIN;
                cnt_nx   = CW'(DRAIN - 1);
            end
            ST_DRAIN: begin
                if (cnt_q == '0) begin
                    state_nx = ST_SWAP;
                end else begin
                    cnt_nx = cnt_q - CW'(1);
                end
            end
            ST_SWAP: begin
                swap     = 1'b1;
                state_nx = ST_RESUME;
            end
            ST_RESUME: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            armed_q <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_nx;
            cnt_q   <= cnt_nx;
            // commit_req is a level; it must drop before it can launch another commit
            if (!commit_req) begin
                armed_q <= 1'b1;
            end else if (launch) begin
                armed_q <= 1'b0;
            end
            if (accept && !addr_ok) begin
                err_q <= 1'b1;
            end
        end
    end

    assign cfg_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign commit_ack = (state_q == ST_RESUME);
    assign src_en     = (state_q == ST_IDLE) || (state_q == ST_RESUME);
    assign err        = err_q;
    assign state_dbg  = state_q;

    fp_cfg_bank #(
        .STAGES (STAGES),
        .WPS    (WPS)
    ) u_bank (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (accept && addr_ok),
        .wr_stage (cfg_stage),
        .wr_word  (cfg_word),
        .wr_data  (cfg_data),
        .swap     (swap),
        .act_cfg  (act_cfg)
    );

endmodule
